scan_doubler: RTL and testbench

//  Consumer of the ULA video stream (15.6 kHz RGBI + syncs + blanks). Stores each incoming

---
 rtl/scan_doubler_pkg.sv | 29 ++
 rtl/scan_line_ram.sv | 33 +++
 rtl/scan_doubler.sv | 134 +++++++++++++
 tb/tb_scan_doubler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_doubler_pkg.sv
// Shared types and constants for the scan doubler: pixel word layout,
// default geometry and the two line lengths the video generator produces.
package scan_doubler_pkg;

  localparam int AW_DEFAULT        = 9;
  localparam int HSYNC_LEN_DEFAULT = 16;

  localparam int LINE_LEN_SHORT = 448;
  localparam int LINE_LEN_LONG  = 456;

  // Bit positions of the colour components inside an rgbi nibble
  localparam int RGBI_R = 3;
  localparam int RGBI_G = 2;
  localparam int RGBI_B = 1;
  localparam int RGBI_I = 0;

  // One stored pixel: the blank flag travels with the colour so the replay
  // reproduces the input blanking exactly.
  typedef struct packed {
    logic       hblank;
    logic [3:0] rgbi;
  } pixel_t;

  // Colour seen on the output: black whenever the stored pixel was blanked.
  function automatic logic [3:0] blank_rgbi(input pixel_t p);
    return p.hblank ? 4'b0000 : p.rgbi;
  endfunction

endpackage

// File: rtl/scan_line_ram.sv
// Two line buffers in one simple dual-port RAM. The bank bit is the address
// MSB; the read port is registered so the array maps onto block RAM.
module scan_line_ram
  import scan_doubler_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic         clock,
  input  logic         we,
  input  logic [AW:0]  waddr,
  input  pixel_t       wdata,
  input  logic         re,
  input  logic [AW:0]  raddr,
  output pixel_t       rdata
);

  pixel_t mem [0:(2**(AW+1))-1];

  // Write port: one input pixel per ce
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port: one output pixel per ce2
  always_ff @(posedge clock) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/scan_doubler.sv
// Scan doubler: captures each 15.6 kHz input line into one bank while the
// previously captured line is replayed twice from the other bank at ce2.
// The replay length is the measured length of the last complete line.
module scan_doubler
  import scan_doubler_pkg::*;
#(
  parameter int AW        = AW_DEFAULT,
  parameter int HSYNC_LEN = HSYNC_LEN_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ce2,
  input  logic       hblank_i,
  input  logic       vblank_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic [3:0] rgbi_i,
  output logic       hblank_o,
  output logic       vblank_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [3:0] rgbi_o
);

  localparam logic [AW-1:0] ADDR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] WX_MAX     = {AW{1'b1}};
  localparam logic [AW-1:0] HSYNC_END  = AW'(HSYNC_LEN);

  logic          wbank_r;
  logic [AW-1:0] wx_r;
  logic [AW-1:0] hlen_r;
  logic          hsync_prev_r;
  logic          started_r;
  logic [AW-1:0] rx_r;
  logic [AW-1:0] rx_d_r;
  logic          valid_d_r;

  logic          line_start_s;
  logic [AW:0]   waddr_s;
  logic [AW:0]   raddr_s;
  pixel_t        wdata_s;
  pixel_t        rdata_s;

  // Line-start detect and RAM addressing; the sync pixel lands at index 0 of the new bank
  always_comb begin
    line_start_s = ce & hsync_i & ~hsync_prev_r;
    wdata_s      = '{hblank: hblank_i, rgbi: rgbi_i};
    raddr_s      = {~wbank_r, rx_r};
    if (line_start_s) begin
      waddr_s = {~wbank_r, ADDR_ZERO};
    end else begin
      waddr_s = {wbank_r, wx_r};
    end
  end

  scan_line_ram #(.AW(AW)) u_ram (
    .clock (clock),
    .we    (ce),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .re    (ce2),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Write side: pixel counter, bank swap, line length measurement, vertical flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wbank_r      <= 1'b0;
      wx_r         <= ADDR_ZERO;
      hlen_r       <= ADDR_ZERO;
      hsync_prev_r <= 1'b0;
      started_r    <= 1'b0;
      vsync_o      <= 1'b0;
      vblank_o     <= 1'b0;
    end else if (ce) begin
      hsync_prev_r <= hsync_i;
      if (line_start_s) begin
        // The first line after reset is partial, so it never becomes a replay length
        hlen_r    <= started_r ? wx_r : ADDR_ZERO;
        started_r <= 1'b1;
        wx_r      <= ADDR_ONE;
        wbank_r   <= ~wbank_r;
        vsync_o   <= vsync_i;
        vblank_o  <= vblank_i;
      end else if (wx_r != WX_MAX) begin
        wx_r <= wx_r + ADDR_ONE;
      end
    end
  end

  // Read side: replay counter wrapping at hlen, restarted by every line start
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_r <= ADDR_ZERO;
    end else if (line_start_s) begin
      rx_r <= ADDR_ZERO;
    end else if (ce2) begin
      if (hlen_r == ADDR_ZERO) begin
        rx_r <= ADDR_ZERO;
      end else if (rx_r == (hlen_r - ADDR_ONE)) begin
        rx_r <= ADDR_ZERO;
      end else begin
        rx_r <= rx_r + ADDR_ONE;
      end
    end
  end

  // Output pipeline: rx and validity follow the RAM read by one stage, then register outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_d_r    <= ADDR_ZERO;
      valid_d_r <= 1'b0;
      hblank_o  <= 1'b0;
      hsync_o   <= 1'b0;
      rgbi_o    <= 4'b0000;
    end else if (ce2) begin
      rx_d_r    <= rx_r;
      valid_d_r <= (hlen_r != ADDR_ZERO);
      if (valid_d_r) begin
        hblank_o <= rdata_s.hblank;
        rgbi_o   <= blank_rgbi(rdata_s);
        hsync_o  <= (rx_d_r < HSYNC_END);
      end else begin
        hblank_o <= 1'b1;
        rgbi_o   <= 4'b0000;
        hsync_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scan_doubler.sv
// Self-checking bench for scan_doubler. A line-level model (captured line
// arrays, replay position as ticks-since-line-start modulo line length)
// predicts every output observed on each ce2 tick.
module tb_scan_doubler;
  import scan_doubler_pkg::*;

  localparam int HS_X    = 344;
  localparam int HS_W    = 32;
  localparam int ACT_W   = 320;
  localparam int MAX_IDX = 511;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       ce       = 1'b0;
  logic       ce2      = 1'b0;
  logic       hblank_i = 1'b0;
  logic       vblank_i = 1'b0;
  logic       hsync_i  = 1'b0;
  logic       vsync_i  = 1'b0;
  logic [3:0] rgbi_i   = 4'h0;
  logic       hblank_o, vblank_o, hsync_o, vsync_o;
  logic [3:0] rgbi_o;

  int errors = 0;
  int checks = 0;
  bit vs_lvl = 1'b0;
  bit vb_lvl = 1'b0;

  // Reference model state
  logic [4:0] cur_line  [512];
  logic [4:0] prev_line [512];
  int         cur_len, hlen_m, starts, cnt;
  bit         prev_hs, vs_m, vb_m;
  logic [5:0] pend;              // {hblank, hsync, rgbi} due on the next tick
  logic [7:0] obs_q[$];          // {hblank, vblank, hsync, vsync, rgbi}
  logic [7:0] exp_q[$];

  scan_doubler #(.AW(9), .HSYNC_LEN(16)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ce2(ce2),
    .hblank_i(hblank_i), .vblank_i(vblank_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .rgbi_i(rgbi_i),
    .hblank_o(hblank_o), .vblank_o(vblank_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .rgbi_o(rgbi_o)
  );

  always #5 clock = ~clock;

  ce_implies_ce2: assert property (@(posedge clock) ce |-> ce2);

  function automatic bit hs_at(input int x);
    return (x >= HS_X) && (x < HS_X + HS_W);
  endfunction

  function automatic bit hb_at(input int x);
    return x >= ACT_W;
  endfunction

  task automatic model_reset;
    cur_len = 0; hlen_m = 0; starts = 0; cnt = 0;
    prev_hs = 1'b0; vs_m = 1'b0; vb_m = 1'b0;
    pend = {1'b1, 1'b0, 4'h0};
    obs_q.delete(); exp_q.delete();
  endtask

  // One ce2 tick of the model; is_ce when the input pixel is also taken
  task automatic model_tick(input bit is_ce);
    logic [5:0] tap;
    logic [4:0] p;
    int r;
    bit ls;
    if (hlen_m == 0) begin
      tap = {1'b1, 1'b0, 4'h0};
    end else begin
      r   = cnt % hlen_m;
      p   = prev_line[r];
      tap = {p[4], (r < 16), (p[4] ? 4'h0 : p[3:0])};
    end
    ls = is_ce && hsync_i && !prev_hs;
    if (ls) begin
      hlen_m = (starts > 0) ? cur_len : 0;
      starts++;
      prev_line = cur_line;
      cur_line[0] = {hblank_i, rgbi_i};
      cur_len = 1;
      vs_m = vsync_i;
      vb_m = vblank_i;
      cnt = 0;
    end else begin
      if (is_ce) begin
        cur_line[cur_len] = {hblank_i, rgbi_i};
        if (cur_len < MAX_IDX) cur_len++;
      end
      cnt++;
    end
    if (is_ce) prev_hs = hsync_i;
    exp_q.push_back({pend[5], vb_m, pend[4], vs_m, pend[3:0]});
    pend = tap;
  endtask

  // One input pixel: four clocks, ce on the first, ce2 on the first and third
  task automatic pix(input bit hs, input bit hb, input logic [3:0] c);
    for (int p = 0; p < 4; p++) begin
      ce = (p == 0); ce2 = (p % 2 == 0);
      hsync_i = hs; hblank_i = hb; rgbi_i = c;
      vsync_i = vs_lvl; vblank_i = vb_lvl;
      @(posedge clock);
      #1;
      if (p % 2 == 0) begin
        model_tick(p == 0);
        obs_q.push_back({hblank_o, vblank_o, hsync_o, vsync_o, rgbi_o});
      end
    end
  endtask

  task automatic run_line(input int len, input bit rnd);
    logic [3:0] c;
    for (int x = 0; x < len; x++) begin
      c = rnd ? 4'($urandom_range(15, 0)) : 4'(x);
      pix(hs_at(x), hb_at(x), c);
    end
  endtask

  task automatic test_reset;
    logic [7:0] o, e;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({hblank_o, vblank_o, hsync_o, vsync_o, rgbi_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_por: outputs=%h required=00", {hblank_o, vblank_o, hsync_o, vsync_o, rgbi_o});
    end
    reset = 1'b1;
    model_reset();
    pix(1'b0, 1'b1, 4'h5);
    checks++;
    if (obs_q[0] !== 8'h80) begin
      errors++;
      $display("FAIL reset_release_blank: outputs=%h required=80", obs_q[0]);
    end
    for (int l = 0; l < 2; l++) run_line(LINE_LEN_SHORT, 1'b1);
    for (int x = 0; x < 200; x++) pix(hs_at(x), hb_at(x), 4'($urandom_range(15, 0)));
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_stream: got %b expected %b", o, e); end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({hblank_o, vblank_o, hsync_o, vsync_o, rgbi_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_midline: outputs=%h required=00", {hblank_o, vblank_o, hsync_o, vsync_o, rgbi_o});
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    for (int l = 0; l < 3; l++) run_line(LINE_LEN_SHORT, 1'b1);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_recover_stream: got %b expected %b", o, e); end
    end
  endtask

  task automatic test_448;
    logic [7:0] o, e;
    int n, hs_cnt, act_cnt;
    for (int l = 0; l < 4; l++) run_line(LINE_LEN_SHORT, 1'b0);
    n = obs_q.size(); hs_cnt = 0; act_cnt = 0;
    for (int i = n - 2 * LINE_LEN_SHORT; i < n; i++) begin
      if (obs_q[i][5]) hs_cnt++;
      if (!obs_q[i][7]) act_cnt++;
    end
    checks++;
    if (hs_cnt != 2 * 16) begin errors++; $display("FAIL l448_hsync_ticks: got %0d required %0d", hs_cnt, 32); end
    checks++;
    if (act_cnt != 2 * ACT_W) begin errors++; $display("FAIL l448_active_ticks: got %0d required %0d", act_cnt, 2 * ACT_W); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL l448_stream: got %b expected %b", o, e); end
    end
  endtask

  task automatic test_hsync;
    logic [7:0] o, e;
    int n, rises, hs_cnt;
    for (int l = 0; l < 2; l++) run_line(LINE_LEN_SHORT, 1'b1);
    n = obs_q.size(); rises = 0; hs_cnt = 0;
    for (int i = n - 2 * LINE_LEN_SHORT; i < n; i++) begin
      if (obs_q[i][5]) hs_cnt++;
      if (obs_q[i][5] && !obs_q[i-1][5]) rises++;
    end
    checks++;
    if (rises != 2) begin errors++; $display("FAIL hsync_pulses: got %0d required 2", rises); end
    checks++;
    if (hs_cnt != 32) begin errors++; $display("FAIL hsync_width_total: got %0d required 32", hs_cnt); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL hsync_stream: got %b expected %b", o, e); end
    end
  endtask

  task automatic test_456;
    logic [7:0] o, e;
    int n, hs_cnt, act_cnt;
    for (int l = 0; l < 4; l++) run_line(LINE_LEN_LONG, 1'b1);
    n = obs_q.size(); hs_cnt = 0; act_cnt = 0;
    for (int i = n - 2 * LINE_LEN_LONG; i < n; i++) begin
      if (obs_q[i][5]) hs_cnt++;
      if (!obs_q[i][7]) act_cnt++;
    end
    checks++;
    if (hs_cnt != 32) begin errors++; $display("FAIL l456_hsync_ticks: got %0d required 32", hs_cnt); end
    checks++;
    if (act_cnt != 2 * ACT_W) begin errors++; $display("FAIL l456_active_ticks: got %0d required %0d", act_cnt, 2 * ACT_W); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL l456_stream: got %b expected %b", o, e); end
    end
  endtask

  task automatic test_long_line;
    logic [7:0] o, e;
    int base, hs_cnt, rises;
    run_line(LINE_LEN_SHORT, 1'b1);
    run_line(600, 1'b1);
    base = obs_q.size();
    run_line(LINE_LEN_SHORT, 1'b1);
    hs_cnt = 0; rises = 0;
    for (int i = base; i < obs_q.size(); i++) begin
      if (obs_q[i][5]) hs_cnt++;
      if (obs_q[i][5] && !obs_q[i-1][5]) rises++;
    end
    checks++;
    if (rises != 2) begin errors++; $display("FAIL long_replay_starts: got %0d required 2", rises); end
    checks++;
    if (hs_cnt != 32) begin errors++; $display("FAIL long_hsync_ticks: got %0d required 32", hs_cnt); end
    run_line(LINE_LEN_SHORT, 1'b1);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL long_stream: got %b expected %b", o, e); end
    end
  endtask

  task automatic test_vsync;
    logic [7:0] o, e;
    vs_lvl = 1'b0; vb_lvl = 1'b0;
    for (int l = 0; l < 2; l++) run_line(LINE_LEN_SHORT, 1'b1);
    for (int x = 0; x < LINE_LEN_SHORT; x++) begin
      if (x == 100) begin vs_lvl = 1'b1; vb_lvl = 1'b1; end
      pix(hs_at(x), hb_at(x), 4'($urandom_range(15, 0)));
      if (x == HS_X - 1) begin
        checks++;
        if ({vsync_o, vblank_o} !== 2'b00) begin
          errors++; $display("FAIL vsync_early: got %b required 00", {vsync_o, vblank_o});
        end
      end
      if (x == HS_X) begin
        checks++;
        if ({vsync_o, vblank_o} !== 2'b11) begin
          errors++; $display("FAIL vsync_at_line_start: got %b required 11", {vsync_o, vblank_o});
        end
      end
    end
    run_line(LINE_LEN_SHORT, 1'b1);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL vsync_stream: got %b expected %b", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_448();
    test_hsync();
    test_456();
    test_long_line();
    test_vsync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
